stream_interp: RTL
==================

Name: stream_interp

Overview:
- AXI-Stream linear-interpolating upsampler, factor L = 2^L_LOG2.
- Expansion-side counterpart to the moving-average reducer in the same DSP stream chain.
- Each accepted input sample x_new, with previous sample x_prev, produces L output beats ramping linearly from x_prev toward x_new; the last beat equals x_new exactly.
- Full throughput: one input per L output beats, no bubbles under continuous flow.

Parameters:
- DW, 8: sample width (unsigned).
- L_LOG2, 2: log2 of the interpolation factor; L = 4 by default; legal range 1..4.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- s_data  input  DW  input sample (unsigned).
- s_valid  input  1  input valid.
- s_ready  output  1  input ready (combinational).
- m_data  output  DW  interpolated output sample (registered).
- m_valid  output  1  output valid (registered).
- m_last  output  1  high on the L-th (final) beat of each input's burst.
- m_ready  input  1  downstream ready.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_last=0, x_prev=0, acc=0, diff=0, cnt=0, state IDLE. Reset mid-burst abandons the burst with no partial completion. The first sample after reset ramps from 0.
- States:
  - IDLE: m_valid=0.
  - EMIT: m_valid=1.
- cnt: 1..L, index of the beat currently presented.
- s_ready = !m_valid || (m_ready && cnt==L). It is combinational from m_ready and state, with no combinational path from s_valid.
- Accept: s_valid && s_ready at a clock edge.
  - diff <= s_data - x_prev, signed DW+1 bits.
  - acc <= x_prev*L + diff, signed DW+L_LOG2+2 bits.
  - m_data <= (x_prev*L + diff) >>> L_LOG2.
  - cnt <= 1; x_prev <= s_data; m_valid <= 1; m_last <= (L==1 impossible, so 0); state EMIT.
- Latency: first output beat visible the cycle after acceptance.
- Advance: m_valid && m_ready && cnt<L.
  - acc <= acc + diff.
  - m_data <= (acc + diff) >>> L_LOG2.
  - cnt <= cnt + 1; m_last <= (cnt+1 == L).
- Last-beat handshake: m_valid && m_ready && cnt==L.
  - If s_valid is also high, the accept rule applies in the same cycle (back-to-back, no bubble).
  - Otherwise m_valid <= 0, m_last <= 0, state IDLE.
- Stall: m_valid && !m_ready. m_data, m_last, m_valid, acc and cnt hold stable (AXI rule); s_ready=0.
- Arithmetic: beat k (1..L) = x_prev + floor(k*(x_new - x_prev)/L), floor toward minus infinity via arithmetic shift. Results always lie within [min(x_prev,x_new), max(x_prev,x_new)], so no saturation is needed. Truncate to DW bits on output.
- s_data is sampled only on accept. Changes while s_ready=0 are ignored.
- m_valid never deasserts without a handshake. Only reset clears it otherwise.

Test Plan (DW=8, L_LOG2=2):
1. Reset; send 8; m_ready=1 -> m_data 2,4,6,8 on consecutive cycles; m_last only on 8; then m_valid=0.
2. After case 1, send 0 -> 6,4,2,0. Then send 255 -> 63,127,191,255.
3. Negative non-divisible step: prime x_prev=10 (send 10, drain), send 7 -> 9,8,7,7 (floor rounding).
4. Backpressure: during beat 2 of a burst, hold m_ready=0 for 3 cycles -> m_data/m_last/m_valid unchanged, s_ready=0, s_data changes ignored; the burst resumes with correct beats 3,4.
5. Back-to-back: s_valid held with samples 4, 8, 12 and m_ready=1 -> 12 contiguous beats 1,2,3,4,5,6,7,8,9,10,11,12; s_ready high only in IDLE and on each last beat; no bubble.
6. Reset asserted mid-burst (after beat 2) -> all outputs 0 immediately. Then send 4 -> 1,2,3,4 (ramp from 0).

Source files
------------

// File: rtl/stream_interp.sv
// rtl/stream_interp.sv - linear-interpolating stream upsampler, factor 2**L_LOG2
//
// Each accepted input sample produces L = 2**L_LOG2 output beats. The beats ramp
// linearly from the previous sample to the new one, and the last beat equals the
// new sample exactly.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   s_data   input sample, DW bits unsigned
//   s_valid  input valid
//   s_ready  input ready; combinational from m_ready and state only
//   m_data   interpolated output sample, registered
//   m_valid  output valid, registered
//   m_last   high on the final beat of each burst
//   m_ready  downstream ready
module stream_interp #(
  parameter int DW     = 8,
  parameter int L_LOG2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready
);

  localparam int L  = 1 << L_LOG2;
  localparam int AW = DW + L_LOG2 + 2;
  localparam int CW = L_LOG2 + 1;
  localparam logic [CW-1:0] CNT_L = CW'(L);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [DW-1:0]         r_x_prev, w_x_prev_nxt;
  logic signed [DW:0]    r_diff, w_diff_nxt;
  logic signed [AW-1:0]  r_acc, w_acc_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DW-1:0]         r_m_data, w_m_data_nxt;
  logic                  r_m_valid, w_m_valid_nxt;
  logic                  r_m_last, w_m_last_nxt;

  logic                  w_on_last;
  logic                  w_accept;
  logic                  w_advance;
  logic [CW-1:0]         w_cnt_inc;
  logic signed [DW:0]    w_diff_new;
  logic signed [AW-1:0]  w_diff_new_ext;
  logic signed [AW-1:0]  w_diff_reg_ext;
  logic signed [AW-1:0]  w_base;
  logic signed [AW-1:0]  w_acc_first;
  logic signed [AW-1:0]  w_acc_step;
  logic signed [AW-1:0]  w_shift_first;
  logic signed [AW-1:0]  w_shift_step;

  assign w_on_last = (r_cnt == CNT_L);
  assign s_ready   = !r_m_valid || (m_ready && w_on_last);
  assign w_accept  = s_valid && s_ready;
  assign w_advance = r_m_valid && m_ready && !w_on_last;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Both operands are zero-extended by one bit so the difference is a proper
  // signed DW+1 value covering -(2**DW-1) .. 2**DW-1.
  assign w_diff_new     = $signed({1'b0, s_data}) - $signed({1'b0, r_x_prev});
  assign w_diff_new_ext = {{(AW-DW-1){w_diff_new[DW]}}, w_diff_new};
  assign w_diff_reg_ext = {{(AW-DW-1){r_diff[DW]}}, r_diff};

  // x_prev*L scaled by L so the accumulator steps by diff each beat; the
  // arithmetic shift then floors toward minus infinity for falling ramps.
  assign w_base        = $signed({2'b00, r_x_prev, {L_LOG2{1'b0}}});
  assign w_acc_first   = w_base + w_diff_new_ext;
  assign w_acc_step    = r_acc + w_diff_reg_ext;
  assign w_shift_first = w_acc_first >>> L_LOG2;
  assign w_shift_step  = w_acc_step >>> L_LOG2;

  always_comb begin
    w_state_nxt   = r_state;
    w_x_prev_nxt  = r_x_prev;
    w_diff_nxt    = r_diff;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_m_data_nxt  = r_m_data;
    w_m_valid_nxt = r_m_valid;
    w_m_last_nxt  = r_m_last;

    // Accept has priority: on a last-beat handshake with s_valid high the next
    // burst starts in the same cycle, so no bubble appears.
    if (w_accept) begin
      w_state_nxt   = EMIT;
      w_x_prev_nxt  = s_data;
      w_diff_nxt    = w_diff_new;
      w_acc_nxt     = w_acc_first;
      w_cnt_nxt     = CW'(1);
      w_m_data_nxt  = w_shift_first[DW-1:0];
      w_m_valid_nxt = 1'b1;
      w_m_last_nxt  = 1'b0;
    end else if (w_advance) begin
      w_acc_nxt     = w_acc_step;
      w_cnt_nxt     = w_cnt_inc;
      w_m_data_nxt  = w_shift_step[DW-1:0];
      w_m_last_nxt  = (w_cnt_inc == CNT_L);
    end else if (r_m_valid && m_ready && w_on_last) begin
      w_state_nxt   = IDLE;
      w_m_valid_nxt = 1'b0;
      w_m_last_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_x_prev  <= '0;
      r_diff    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x_prev  <= w_x_prev_nxt;
      r_diff    <= w_diff_nxt;
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_m_data  <= w_m_data_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_m_last  <= w_m_last_nxt;
    end
  end

  assign m_data  = r_m_data;
  // m_valid tracks the state register; keeping the flop makes it glitch-free.
  assign m_valid = r_m_valid && (r_state == EMIT);
  assign m_last  = r_m_last;

endmodule
